coeff_load_sequencer: RTL and testbench
=======================================

// Module: coeff_load_sequencer
// PURPOSE
// Sequences loading of the right-channel filter tables: zero-fills the 512-entry coefficient
// memory one address per cycle, then routes an incoming stream of 16-bit words first into the
// 16-entry rj table, then into the coefficient memory. Sits between the serial word assembler
// and the coefficient/rj memories and replaces the asynchronous clear and write strobe with
// synchronous, single-cycle write enables.
// PARAMETERS
// DW          16   data word width
// RJ_DEPTH    16   rj table entries (power of 2)
// COEFF_DEPTH 512  coefficient memory entries (power of 2)
// PORTS
// Sclk        in   1   system clock, all logic on posedge
// clear       in   1   synchronous active-high reset
// start_load  in   1   1-cycle pulse: begin (or restart) a full load
// word_valid  in   1   1-cycle strobe: word_in holds a new word
// word_in     in   DW  incoming word
// rj_we       out  1   rj table write enable
// rj_addr     out  4   rj table write address
// coeff_we    out  1   coefficient memory write enable
// coeff_addr  out  9   coefficient memory write address
// wdata       out  DW  write data to both memories
// busy        out  1   high in CLEAR, LOAD_RJ, LOAD_COEFF
// load_done   out  1   high in DONE; tables valid for the filter datapath
// load_err    out  1   sticky: word_valid seen during CLEAR
// BEHAVIOUR
// - Reset (clear=1 at posedge): state IDLE, all counters 0, every output 0, load_err cleared.
// - States: IDLE, ZERO, LOAD_RJ, LOAD_COEFF, DONE. All outputs registered.
// - IDLE/DONE + start_load -> ZERO, cnt=0, load_done drops the next cycle.
// - ZERO: each cycle coeff_we=1, coeff_addr=cnt, wdata=0; cnt increments; after
//   addr COEFF_DEPTH-1 is written -> LOAD_RJ, cnt=0. Exactly COEFF_DEPTH cycles.
//   word_valid in ZERO is dropped and sets load_err.
// - LOAD_RJ: on word_valid, next cycle rj_we=1, rj_addr=cnt, wdata=word_in (latency 1);
//   after entry RJ_DEPTH-1 -> LOAD_COEFF, cnt=0.
// - LOAD_COEFF: on word_valid, next cycle coeff_we=1, coeff_addr=cnt, wdata=word_in;
//   after entry COEFF_DEPTH-1 -> DONE.
// - Write enables are single-cycle pulses; rj_we and coeff_we never high together.
// - Counter wraps only via state change; no write beyond the last index in any state.
// - start_load while busy: abort, restart at ZERO with cnt=0 (write in flight that cycle
//   still completes); load_err kept.
// - start_load and word_valid in the same cycle: start wins, word dropped, no load_err.
// - clear mid-load: immediate return to IDLE; partial memory contents undefined to user.
// - DONE holds until start_load or clear; word_valid in DONE/IDLE ignored.
// - Addresses hold last value when enable low; wdata returns to 0 when no write.
// STRUCTURE
// - Shared package: state encoding (3-bit enum), DW, RJ_DEPTH, COEFF_DEPTH, address widths
//   ($clog2 of depths) used also by the memories and filter controller.
// - Single module; no sub-module needed (one FSM + one shared counter).
// TESTING
// - clear=1 two cycles -> all outputs 0, state IDLE; start_load ignored while clear=1.
// - start_load, no words -> 512 cycles coeff_we=1 wdata=0 addr 0..511, then busy with rj_we=0.
// - full load: 16 words 0x0100..0x010F then 512 words 0x8000+i with gaps of 0-3 cycles ->
//   rj_addr 0..15 and coeff_addr 0..511 written with matching data, load_done=1 after last.
// - word_valid during ZERO at cycle 100 -> no write, load_err=1 remains to end of load.
// - start_load after 5 coefficient words -> restart ZERO at addr 0, final tables match 2nd stream.
// - start_load and word_valid same cycle in DONE -> ZERO entered, no rj_we, load_err=0.

Source files
------------

// File: rtl/coeff_load_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// coeff_load_sequencer_pkg
// Shared definitions for loading the right-channel filter tables. These are
// used by the load sequencer, the coefficient/rj memories and the filter
// controller.
//   DW          : width of the data words written into both tables
//   RJ_DEPTH    : number of entries in the rj table (power of 2)
//   COEFF_DEPTH : number of entries in the coefficient memory (power of 2)
//   RJ_AW       : rj table address width
//   COEFF_AW    : coefficient memory address width
//   CNT_W       : width of the shared sequencing counter, which covers the
//                 larger of the two tables
//   load_state_t: 3-bit encoding of the load sequencer states
// ---------------------------------------------------------------------------
package coeff_load_sequencer_pkg;

    localparam int DW          = 16;
    localparam int RJ_DEPTH    = 16;
    localparam int COEFF_DEPTH = 512;

    localparam int RJ_AW    = $clog2(RJ_DEPTH);
    localparam int COEFF_AW = $clog2(COEFF_DEPTH);
    localparam int CNT_W    = (COEFF_AW > RJ_AW) ? COEFF_AW : RJ_AW;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ZERO       = 3'd1,
        ST_LOAD_RJ    = 3'd2,
        ST_LOAD_COEFF = 3'd3,
        ST_DONE       = 3'd4
    } load_state_t;

endpackage

// File: rtl/coeff_load_sequencer.sv
// ---------------------------------------------------------------------------
// coeff_load_sequencer
// Sequences loading of the right-channel filter tables. After start_load the
// coefficient memory is zero-filled one address per cycle. The incoming word
// stream is then routed first into the rj table and then into the coefficient
// memory. Every output is registered, and each write enable is a
// single-cycle pulse.
//
// Ports
//   Sclk        in   system clock; all logic runs on the rising edge
//   clear       in   synchronous active-high reset
//   start_load  in   1-cycle pulse: begin a full load, or restart one
//   word_valid  in   1-cycle strobe: word_in holds a new word
//   word_in     in   incoming word (DW bits)
//   rj_we       out  rj table write enable
//   rj_addr     out  rj table write address
//   coeff_we    out  coefficient memory write enable
//   coeff_addr  out  coefficient memory write address
//   wdata       out  write data to both tables (0 when no write is issued)
//   busy        out  high while zero-filling or loading
//   load_done   out  high once both tables are fully loaded
//   load_err    out  sticky: a word arrived during zero-fill; only clear
//                    resets it
// ---------------------------------------------------------------------------
module coeff_load_sequencer
    import coeff_load_sequencer_pkg::*;
(
    input  logic                Sclk,
    input  logic                clear,
    input  logic                start_load,
    input  logic                word_valid,
    input  logic [DW-1:0]       word_in,
    output logic                rj_we,
    output logic [RJ_AW-1:0]    rj_addr,
    output logic                coeff_we,
    output logic [COEFF_AW-1:0] coeff_addr,
    output logic [DW-1:0]       wdata,
    output logic                busy,
    output logic                load_done,
    output logic                load_err
);

    localparam logic [CNT_W-1:0] LAST_RJ    = CNT_W'(RJ_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_COEFF = CNT_W'(COEFF_DEPTH - 1);

    load_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;

    // A single counter is shared by all three phases. It is only reset
    // through a phase change, so no phase can address past its table.
    always_ff @(posedge Sclk) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            rj_we      <= 1'b0;
            rj_addr    <= '0;
            coeff_we   <= 1'b0;
            coeff_addr <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Enables are pulses and wdata idles at zero. Addresses keep
            // their last value.
            rj_we    <= 1'b0;
            coeff_we <= 1'b0;
            wdata    <= '0;

            if (start_load) begin
                // start_load has priority over everything, including a word
                // arriving in the same cycle. That word is dropped and does
                // not count as an error. A write already registered in the
                // previous cycle has been presented to the memory by now, so
                // aborting here never cuts one short.
                r_state   <= ST_ZERO;
                r_cnt     <= '0;
                busy      <= 1'b1;
                load_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_ZERO: begin
                        coeff_we   <= 1'b1;
                        coeff_addr <= r_cnt[COEFF_AW-1:0];
                        if (word_valid) begin
                            load_err <= 1'b1;
                        end
                        if (r_cnt == LAST_COEFF) begin
                            r_state <= ST_LOAD_RJ;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    ST_LOAD_RJ: begin
                        if (word_valid) begin
                            rj_we   <= 1'b1;
                            rj_addr <= r_cnt[RJ_AW-1:0];
                            wdata   <= word_in;
                            if (r_cnt == LAST_RJ) begin
                                r_state <= ST_LOAD_COEFF;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end

                    ST_LOAD_COEFF: begin
                        if (word_valid) begin
                            coeff_we   <= 1'b1;
                            coeff_addr <= r_cnt[COEFF_AW-1:0];
                            wdata      <= word_in;
                            if (r_cnt == LAST_COEFF) begin
                                // load_done rises in the same cycle as the
                                // last coefficient write pulse.
                                r_state   <= ST_DONE;
                                busy      <= 1'b0;
                                load_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end

                    ST_IDLE, ST_DONE: begin
                        // Stray words are ignored. DONE holds until the next
                        // start_load or clear.
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coeff_load_sequencer.sv
module tb_coeff_load_sequencer;
    import coeff_load_sequencer_pkg::*;

    logic Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    logic                clear, start_load, word_valid;
    logic [DW-1:0]       word_in;
    logic                rj_we, coeff_we, busy, load_done, load_err;
    logic [RJ_AW-1:0]    rj_addr;
    logic [COEFF_AW-1:0] coeff_addr;
    logic [DW-1:0]       wdata;

    coeff_load_sequencer dut (
        .Sclk       (Sclk),
        .clear      (clear),
        .start_load (start_load),
        .word_valid (word_valid),
        .word_in    (word_in),
        .rj_we      (rj_we),
        .rj_addr    (rj_addr),
        .coeff_we   (coeff_we),
        .coeff_addr (coeff_addr),
        .wdata      (wdata),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit exp_err = 1'b0;

    // The shadow memories capture what the DUT actually writes. The expected
    // tables hold the stream sent by the bench.
    logic [DW-1:0] sh_rj    [RJ_DEPTH];
    logic [DW-1:0] sh_coeff [COEFF_DEPTH];
    logic [DW-1:0] exp_rj   [RJ_DEPTH];
    logic [DW-1:0] exp_coeff[COEFF_DEPTH];

    typedef struct {
        string       name;
        logic        clr, st, wv;
        logic [15:0] w;
        logic        e_busy, e_done, e_err, e_rjwe, e_cwe;
        logic [8:0]  e_caddr;
        logic [15:0] e_wdata;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(string nm, logic clr, logic st, logic wv, logic [15:0] w,
                                logic eb, logic ed, logic ee, logic erj, logic ecw,
                                logic [8:0] ea, logic [15:0] edat);
        vec_t v;
        v.name = nm; v.clr = clr; v.st = st; v.wv = wv; v.w = w;
        v.e_busy = eb; v.e_done = ed; v.e_err = ee; v.e_rjwe = erj; v.e_cwe = ecw;
        v.e_caddr = ea; v.e_wdata = edat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs take effect at this edge, and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge Sclk);
        #1;
        if (mon_en) begin
            if (rj_we)    sh_rj[rj_addr]       = wdata;
            if (coeff_we) sh_coeff[coeff_addr] = wdata;
            chk("we_exclusive", 64'(rj_we & coeff_we), 64'd0);
            if (!rj_we && !coeff_we) chk("wdata_idle_zero", 64'(wdata), 64'd0);
        end
    endtask

    task automatic poison_shadows();
        for (int i = 0; i < RJ_DEPTH; i++)    sh_rj[i]    = 16'hDEAD;
        for (int i = 0; i < COEFF_DEPTH; i++) sh_coeff[i] = 16'hDEAD;
    endtask

    // mode 0: the fixed stream 0x0100+i / 0x8000+i. mode 1: random words.
    task automatic fill_stream(input int mode);
        for (int i = 0; i < RJ_DEPTH; i++)
            exp_rj[i] = (mode == 0) ? 16'(16'h0100 + i) : 16'($urandom);
        for (int i = 0; i < COEFF_DEPTH; i++)
            exp_coeff[i] = (mode == 0) ? 16'(16'h8000 + i) : 16'($urandom);
    endtask

    task automatic do_start();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        chk("start_busy", 64'({busy, load_done, rj_we, coeff_we}), 64'b1000);
    endtask

    // Zero-fill: one write per cycle at address i with data 0. Optionally
    // inject a word at cycle err_at, which must be dropped and flagged.
    task automatic zero_phase(input int err_at);
        for (int i = 0; i < COEFF_DEPTH; i++) begin
            word_valid = (i == err_at);
            word_in    = 16'($urandom);
            tick();
            word_valid = 1'b0;
            if (i == err_at) exp_err = 1'b1;
            chk("zero_write", 64'({rj_we, coeff_we, coeff_addr, wdata}),
                64'({1'b0, 1'b1, 9'(i), 16'h0000}));
            chk("zero_err", 64'(load_err), 64'(exp_err));
        end
    endtask

    // Send n words from the expected table, with 0-3 idle cycles before each one.
    task automatic send_stream(input bit to_coeff, input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_no_write", 64'({rj_we, coeff_we}), 64'd0);
            end
            word_valid = 1'b1;
            word_in    = to_coeff ? exp_coeff[i] : exp_rj[i];
            tick();
            word_valid = 1'b0;
            if (!to_coeff)
                chk("rj_write", 64'({rj_we, coeff_we, rj_addr, wdata}),
                    64'({1'b1, 1'b0, 4'(i), exp_rj[i]}));
            else
                chk("coeff_write", 64'({rj_we, coeff_we, coeff_addr, wdata, load_done, busy}),
                    64'({1'b0, 1'b1, 9'(i), exp_coeff[i],
                         i == COEFF_DEPTH - 1, i != COEFF_DEPTH - 1}));
            chk("err_hold", 64'(load_err), 64'(exp_err));
        end
    endtask

    task automatic check_tables();
        for (int i = 0; i < RJ_DEPTH; i++)
            chk($sformatf("rj_table[%0d]", i), 64'(sh_rj[i]), 64'(exp_rj[i]));
        for (int i = 0; i < COEFF_DEPTH; i++)
            chk($sformatf("coeff_table[%0d]", i), 64'(sh_coeff[i]), 64'(exp_coeff[i]));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_outputs", 64'({busy, load_done, load_err, rj_we, coeff_we, wdata}), 64'd0);
        exp_err = 1'b0;
    endtask

    initial begin
        clear = 1'b1; start_load = 1'b0; word_valid = 1'b0; word_in = '0;

        //           name                 clr st wv word      busy done err rjwe cwe addr  wdata
        vecs[0] = mk("clr_with_start",    1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 9'd0, 16'h0);
        vecs[1] = mk("clr_hold",          1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 9'd0, 16'h0);
        vecs[2] = mk("idle_word_ignored", 0, 0, 1, 16'h1234, 0, 0, 0, 0, 0, 9'd0, 16'h0);
        vecs[3] = mk("start_from_idle",   0, 1, 0, 16'h0000, 1, 0, 0, 0, 0, 9'd0, 16'h0);
        vecs[4] = mk("zero_addr0",        0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 9'd0, 16'h0);
        vecs[5] = mk("zero_word_err",     0, 0, 1, 16'hBEEF, 1, 0, 1, 0, 1, 9'd1, 16'h0);
        vecs[6] = mk("zero_addr2",        0, 0, 0, 16'h0000, 1, 0, 1, 0, 1, 9'd2, 16'h0);
        vecs[7] = mk("abort_restart",     0, 1, 0, 16'h0000, 1, 0, 1, 0, 0, 9'd2, 16'h0);
        vecs[8] = mk("restart_addr0",     0, 0, 0, 16'h0000, 1, 0, 1, 0, 1, 9'd0, 16'h0);
        vecs[9] = mk("clear_mid_load",    1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 9'd0, 16'h0);

        for (int v = 0; v < 10; v++) begin
            clear = vecs[v].clr; start_load = vecs[v].st;
            word_valid = vecs[v].wv; word_in = vecs[v].w;
            tick();
            chk(vecs[v].name,
                64'({busy, load_done, load_err, rj_we, coeff_we, rj_addr, coeff_addr, wdata}),
                64'({vecs[v].e_busy, vecs[v].e_done, vecs[v].e_err, vecs[v].e_rjwe,
                     vecs[v].e_cwe, 4'd0, vecs[v].e_caddr, vecs[v].e_wdata}));
            if (v == 1) mon_en = 1'b1;
        end
        clear = 1'b0; start_load = 1'b0; word_valid = 1'b0;
        exp_err = 1'b0;

        // Zero-fill with no incoming words. Afterwards the sequencer waits in the rj phase.
        do_start();
        zero_phase(-1);
        for (int i = 0; i < 20; i++) tick();
        chk("wait_rj_after_zero", 64'({busy, rj_we, coeff_we, load_done}), 64'b1000);
        do_clear();

        // Full load with the fixed stream and random gaps.
        poison_shadows();
        fill_stream(0);
        do_start();
        zero_phase(-1);
        send_stream(1'b0, RJ_DEPTH);
        send_stream(1'b1, COEFF_DEPTH);
        check_tables();
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1; word_in = 16'($urandom);
            tick();
            word_valid = 1'b0;
            chk("done_word_ignored", 64'({rj_we, coeff_we, load_done, busy, load_err}), 64'b00100);
        end

        // A word arriving during zero-fill at cycle 100 sets the sticky error.
        poison_shadows();
        fill_stream(1);
        do_start();
        zero_phase(100);
        send_stream(1'b0, RJ_DEPTH);
        send_stream(1'b1, COEFF_DEPTH);
        check_tables();
        chk("err_at_done", 64'({load_err, load_done}), 64'b11);
        do_clear();

        // Abort after 5 coefficient words, then reload a second stream.
        poison_shadows();
        fill_stream(1);
        do_start();
        zero_phase(-1);
        send_stream(1'b0, RJ_DEPTH);
        send_stream(1'b1, 5);
        fill_stream(1);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        chk("abort_in_coeff", 64'({busy, load_done, rj_we, coeff_we, coeff_addr}),
            64'({4'b1000, 9'd4}));
        zero_phase(-1);
        send_stream(1'b0, RJ_DEPTH);
        send_stream(1'b1, COEFF_DEPTH);
        check_tables();

        // start_load and word_valid in the same cycle while in DONE.
        start_load = 1'b1; word_valid = 1'b1; word_in = 16'hA5A5;
        tick();
        start_load = 1'b0; word_valid = 1'b0;
        chk("done_start_and_word", 64'({busy, load_done, load_err, rj_we, coeff_we, wdata}),
            64'({5'b10000, 16'h0}));
        tick();
        chk("done_restart_zero", 64'({coeff_we, coeff_addr, wdata}), 64'({1'b1, 9'd0, 16'h0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
